fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Fetch controller that owns the program counter and sequences instruction fetch from instruction memory. It issues one outstanding request at a time, advances the PC by 4 per accepted request, and applies branch/jump redirects (target = PC + ImmOp, computed by the execute stage). Killed in-flight fetches are discarded, and one fetched instruction is buffered toward decode under a valid/ready handshake. It sits between the branch unit, instruction memory and decode.

## Interface
- DATA_WIDTH, 32, width of PC, addresses and instruction word
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- redirect_valid  input  1  single-cycle redirect request (taken branch/jump)
- redirect_target  input  DATA_WIDTH  new PC when redirect_valid=1
- imem_req  output  1  fetch request
- imem_addr  output  DATA_WIDTH  fetch address; always equals internal pc_q
- imem_gnt  input  1  memory accepts request this cycle (meaningful only with imem_req=1)
- imem_rvalid  input  1  response valid; at least 1 cycle after gnt, exactly one per gnt
- imem_rdata  input  DATA_WIDTH  instruction word with imem_rvalid
- instr_valid  output  1  buffered instruction valid toward decode
- instr  output  DATA_WIDTH  buffered instruction
- instr_pc  output  DATA_WIDTH  address of buffered instruction
- decode_ready  input  1  decode accepts; transfer when instr_valid && decode_ready
- misalign_fault  output  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- Registers: pc_q (next fetch address), inflight_pc_q, output buffer {instr_valid, instr, instr_pc}, FSM state.
- States: IDLE, REQ, WAIT, DRAIN. Reset enters IDLE; IDLE -> REQ unconditionally next cycle.
- REQ: imem_req = (!instr_valid || decode_ready) && !misalign_fault. On imem_req && imem_gnt without redirect: inflight_pc_q <= pc_q, pc_q <= pc_q + 4, -> WAIT.
- WAIT: imem_req=0. On imem_rvalid without redirect: buffer <= {1, imem_rdata, inflight_pc_q}, -> REQ.
- DRAIN: imem_req=0; waits for the response of a killed request. On imem_rvalid: discard, -> REQ.
- Redirect (highest priority, any state except IDLE): pc_q <= redirect_target, instr_valid <= 0 (buffered instruction dropped even if decode_ready=1 that cycle). Next state:
  - REQ with gnt that cycle: DRAIN (granted request killed, pc_q not incremented).
  - REQ without gnt: REQ.
  - WAIT with rvalid same cycle: REQ, data dropped.
  - WAIT without rvalid: DRAIN.
  - DRAIN: DRAIN; pc_q updated again if rvalid is absent. If rvalid arrives in the same cycle, it is discarded and the next state is REQ.
- Buffer never overflows: a request is issued only if the buffer is empty or drains in the grant cycle.
- Buffer clears on transfer (instr_valid && decode_ready) unless reloaded in the same cycle. Reload cannot coincide with a transfer by construction.
- PC arithmetic is modulo 2^DATA_WIDTH: 0xFFFF_FFFC + 4 = 0x0000_0000.
- imem_rvalid in IDLE or REQ is ignored; memory is reset together with this block.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, misalign_fault=0.
- First imem_req=1 is in the second cycle after rst deasserts (the IDLE cycle comes first).
- Latency: gnt in cycle N, rvalid in cycle N+k (k>=1), instr_valid=1 from cycle N+k+1.
- Peak throughput is one instruction per 2 cycles (REQ, WAIT) with k=1 and gnt held high.
- Redirect in cycle N: imem_addr=redirect_target in cycle N+1; instr_valid=0 in cycle N+1.
- imem_req depends combinationally on decode_ready; all other outputs are registered.
- Asynchronous reset mid-operation aborts any in-flight request; outputs take reset values immediately.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined:
  - A redirect with redirect_target[1:0] != 0 performs the normal flush/kill and loads pc_q <= target.
  - It also sets misalign_fault=1 from the next cycle, which holds imem_req=0.
  - The next redirect with an aligned target clears misalign_fault in that cycle, and fetch resumes.
- Not defined: redirect_target[1:0] is forced to 2'b00 on load; misalign_fault is tied 0.

## Test plan
- Reset, RESET_PC=0, gnt=1, k=1, decode_ready=1 -> imem_addr 0x0,0x4,0x8; instr_pc 0x0,0x4,0x8 with matching instr; imem_req=0 in the first cycle after rst release.
- Buffer full at 0x4 with decode_ready=0 for 5 cycles -> instr/instr_pc stable, imem_req=0, no gnt. decode_ready=1 -> transfer, then request to 0x8.
- Redirect to 0x100 during WAIT, rvalid 2 cycles later -> that data never appears on instr; next instr_pc=0x100.
- Redirect to 0x200 in the same cycle as rvalid, and redirect in REQ coincident with gnt -> data dropped, DRAIN entered for the gnt case, next fetched instr_pc=0x200.
- Redirect to 0xFFFF_FFFC -> instr_pc 0xFFFF_FFFC, then 0x0000_0000.
- Redirect to 0x102:
  - With FETCH_MISALIGN_CHECK_EN: misalign_fault=1, imem_req stays 0; a later redirect to 0x300 clears the fault and fetches 0x300.
  - Without the macro: fetch address is 0x100.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction memory port and decode handshake.
// master = fetch_sequencer, slave = memory/decode side.
interface fetch_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_gnt;
  logic                  imem_rvalid;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  instr_valid;
  logic [DATA_WIDTH-1:0] instr;
  logic [DATA_WIDTH-1:0] instr_pc;
  logic                  decode_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output instr_valid,
    output instr,
    output instr_pc,
    input  decode_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output decode_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// PC owner and single-outstanding fetch sequencer with redirect kill.
// Optional FETCH_MISALIGN_CHECK_EN: sticky fault on misaligned redirect.
module fetch_sequencer #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_target,
  fetch_sequencer_if.master     bus,
  output logic                  misalign_fault
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] inflight_pc_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [DATA_WIDTH-1:0] instr_pc_q;
  logic                  valid_q;
  logic                  fault_q;

  logic                  redir;
  logic                  req;
  logic                  fire;
  logic                  load;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] target;

  localparam logic [DATA_WIDTH-1:0] LOW2 =
    {{(DATA_WIDTH-2){1'b0}}, 2'b11};

`ifdef FETCH_MISALIGN_CHECK_EN
  assign target = redirect_target;
`else
  assign target = redirect_target & ~LOW2;
`endif

  // Handshake qualifiers; imem_req follows decode_ready combinationally.
  always_comb begin
    redir = redirect_valid && (state_q != IDLE);
    req   = (state_q == REQ)
          && (!valid_q || bus.decode_ready)
          && !fault_q;
    fire  = req && bus.imem_gnt;
    load  = (state_q == WAIT) && bus.imem_rvalid && !redir;
    xfer  = valid_q && bus.decode_ready;
  end

  // Next-state: a killed grant must still drain its response.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (fire) state_d = redir ? DRAIN : WAIT;
      end
      WAIT: begin
        if (bus.imem_rvalid) state_d = REQ;
        else if (redir)      state_d = DRAIN;
      end
      DRAIN: begin
        if (bus.imem_rvalid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // PC: redirect wins over increment; a killed grant never increments.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
    end else begin
      if (redir)
        pc_q <= target;
      else if (fire)
        pc_q <= pc_q + DATA_WIDTH'(4);
      if (fire && !redir)
        inflight_pc_q <= pc_q;
    end
  end

  // One-entry output buffer toward decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else if (redir) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q    <= 1'b1;
      instr_q    <= bus.imem_rdata;
      instr_pc_q <= inflight_pc_q;
    end else if (xfer) begin
      valid_q <= 1'b0;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // Sticky fault; any redirect re-evaluates alignment of its target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       fault_q <= 1'b0;
    else if (redir) fault_q <= |redirect_target[1:0];
  end
`else
  assign fault_q = 1'b0;
`endif

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign misalign_fault  = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: memory responder, stream model, directed cases.
// Model tracks expected PC, outstanding fetch and buffered instruction.
module tb_fetch_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         redirect_valid;
  logic [W-1:0] redirect_target;
  logic         misalign_fault;

  always #5 clk = ~clk;

  fetch_sequencer_if #(.DATA_WIDTH(W)) bus ();

  fetch_sequencer #(
    .DATA_WIDTH(W),
    .RESET_PC  (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .bus            (bus),
    .misalign_fault (misalign_fault)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic timeout(string name);
    total++;
    bad++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic logic [31:0] f(logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Memory: one response per grant, mem_k cycles later.
  typedef struct {
    logic [31:0] a;
    int          due;
  } mem_t;

  mem_t        mq[$];
  int          cyc   = 0;
  int          mem_k = 1;
  logic [31:0] gq[$];
  logic [31:0] xq[$];
  logic [31:0] xi[$];

  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rst) begin
      mq.delete();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
    end else if (mq.size() > 0 && mq[0].due == cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = f(mq[0].a);
      void'(mq.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
    end
  end

  // Model state
  logic [31:0] m_pc, m_instr, m_ipc, m_opc;
  bit          m_valid, m_out, m_alive, m_fault, m_first;

  // Compare against model each cycle, then advance the model.
  always @(negedge clk) begin
    bit          er, fire, rv, red;
    logic [31:0] tgt;
    if (!rst) begin
      m_pc    = 32'h0;
      m_valid = 0;
      m_out   = 0;
      m_alive = 0;
      m_fault = 0;
      m_first = 1;
    end else begin
      er = !m_first && !m_out && !m_fault
         && (!m_valid || bus.decode_ready);
      chk("imem_req", 32'(bus.imem_req), 32'(er));
      chk("imem_addr", bus.imem_addr, m_pc);
      chk("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
      if (m_valid) begin
        chk("instr", bus.instr, m_instr);
        chk("instr_pc", bus.instr_pc, m_ipc);
      end
      chk("misalign_fault", 32'(misalign_fault), 32'(m_fault));

      if (bus.imem_req && bus.imem_gnt) begin
        gq.push_back(bus.imem_addr);
        mq.push_back('{bus.imem_addr, cyc + mem_k});
      end
      if (bus.instr_valid && bus.decode_ready && !redirect_valid) begin
        xq.push_back(bus.instr_pc);
        xi.push_back(bus.instr);
      end

      fire = er && bus.imem_gnt;
      rv   = bus.imem_rvalid;
      red  = redirect_valid && !m_first;
`ifdef FETCH_MISALIGN_CHECK_EN
      tgt = redirect_target;
`else
      tgt = {redirect_target[31:2], 2'b00};
`endif
      if (m_valid && bus.decode_ready) m_valid = 0;
      if (m_out && rv) begin
        m_out = 0;
        if (m_alive && !red) begin
          m_valid = 1;
          m_instr = f(m_opc);
          m_ipc   = m_opc;
        end
      end else if (m_out && red) begin
        m_alive = 0;
      end
      if (fire) begin
        m_out   = 1;
        m_alive = !red;
        m_opc   = m_pc;
      end
      if (red) begin
        m_pc    = tgt;
        m_valid = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
        m_fault = (redirect_target[1:0] != 2'b00);
`endif
      end else if (fire) begin
        m_pc = m_pc + 32'd4;
      end
      m_first = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(logic [31:0] t);
    redirect_valid  = 1'b1;
    redirect_target = t;
    tick();
    redirect_valid  = 1'b0;
  endtask

  task automatic wait_xfer(output logic [31:0] pc);
    int n0 = xq.size();
    int t  = 0;
    pc = 32'hDEAD_BEEF;
    while (xq.size() == n0 && t < 100) begin
      tick();
      t++;
    end
    if (xq.size() == n0) timeout("wait_xfer");
    else pc = xq[n0];
  endtask

  task automatic wait_grant(output logic [31:0] a);
    int n0 = gq.size();
    int t  = 0;
    a = 32'hDEAD_BEEF;
    while (gq.size() == n0 && t < 100) begin
      tick();
      t++;
    end
    if (gq.size() == n0) timeout("wait_grant");
    else a = gq[n0];
  endtask

  initial begin
    logic [31:0] p;
    int          g0;
    int          t;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    bus.imem_gnt     = 1'b1;
    bus.decode_ready = 1'b1;
    bus.imem_rvalid  = 1'b0;
    bus.imem_rdata   = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(bus.imem_req), 32'h0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    chk("rst_fault", 32'(misalign_fault), 32'h0);
    rst = 1'b1;
    #3;
    chk("idle_req", 32'(bus.imem_req), 32'h0);

    // Straight-line fetch
    t = 0;
    while (xq.size() < 3 && t < 100) begin
      tick();
      t++;
    end
    if (xq.size() < 3) begin
      timeout("seq_fetch");
    end else begin
      chk("gnt0", gq[0], 32'h0);
      chk("gnt1", gq[1], 32'h4);
      chk("gnt2", gq[2], 32'h8);
      chk("xpc0", xq[0], 32'h0);
      chk("xpc1", xq[1], 32'h4);
      chk("xpc2", xq[2], 32'h8);
      chk("xi0", xi[0], 32'h1357_9BDF);
      chk("xi1", xi[1], 32'h1357_9BDB);
      chk("xi2", xi[2], 32'h1357_9BD7);
    end

    // Buffer full with decode stalled
    bus.decode_ready = 1'b0;
    redir(32'h4);
    t = 0;
    while (!bus.instr_valid && t < 50) begin
      tick();
      t++;
    end
    chk("stall_pc", bus.instr_pc, 32'h4);
    g0 = gq.size();
    repeat (5) tick();
    chk("stall_pc_hold", bus.instr_pc, 32'h4);
    chk("stall_instr", bus.instr, 32'h1357_9BDB);
    chk("stall_req", 32'(bus.imem_req), 32'h0);
    chk("stall_nogrant", 32'(gq.size()), 32'(g0));
    bus.decode_ready = 1'b1;
    wait_grant(p);
    chk("after_stall_gnt", p, 32'h8);

    // Redirect during WAIT, response 2 cycles later
    mem_k = 3;
    wait_grant(p);
    redir(32'h100);
    mem_k = 1;
    wait_xfer(p);
    chk("redir_wait", p, 32'h100);

    // Second redirect while draining
    mem_k = 4;
    wait_grant(p);
    redir(32'h180);
    redir(32'h1C0);
    mem_k = 1;
    wait_xfer(p);
    chk("redir_drain", p, 32'h1C0);

    // Redirect coincident with rvalid
    wait_grant(p);
    redir(32'h200);
    wait_xfer(p);
    chk("redir_rvalid", p, 32'h200);

    // Redirect coincident with grant in REQ
    wait_grant(p);
    tick();
    redir(32'h240);
    wait_grant(p);
    chk("redir_gnt_addr", p, 32'h240);
    wait_xfer(p);
    chk("redir_gnt_xfer", p, 32'h240);

    // Wraparound
    redir(32'hFFFF_FFFC);
    wait_xfer(p);
    chk("wrap0", p, 32'hFFFF_FFFC);
    wait_xfer(p);
    chk("wrap1", p, 32'h0);

    // Misaligned redirect
    redir(32'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
    repeat (3) tick();
    chk("fault_set", 32'(misalign_fault), 32'h1);
    g0 = gq.size();
    repeat (5) tick();
    chk("fault_nogrant", 32'(gq.size()), 32'(g0));
    chk("fault_req", 32'(bus.imem_req), 32'h0);
    redir(32'h300);
    wait_xfer(p);
    chk("fault_resume", p, 32'h300);
    chk("fault_clear", 32'(misalign_fault), 32'h0);
`else
    wait_xfer(p);
    chk("misalign_forced", p, 32'h100);
    chk("fault_tied", 32'(misalign_fault), 32'h0);
`endif

    // Asynchronous reset mid-operation
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_req", 32'(bus.imem_req), 32'h0);
    chk("arst_addr", bus.imem_addr, 32'h0);
    chk("arst_valid", 32'(bus.instr_valid), 32'h0);
    chk("arst_instr", bus.instr, 32'h0);
    chk("arst_instr_pc", bus.instr_pc, 32'h0);
    chk("arst_fault", 32'(misalign_fault), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    wait_xfer(p);
    chk("arst_refetch", p, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
